// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle: instruction-cache enqueue side and decode dequeue side.
// Payload widths follow the compressed-extension setting.
interface fetch_queue_if #(
  parameter bit ENABLE_C_EXTENSION = 1'b0
);
  localparam int PC_BITS  = ENABLE_C_EXTENSION ? 31 : 30;
  localparam int IDX_BITS = ENABLE_C_EXTENSION ? 2 : 1;

  logic                enq_valid_i;
  logic                enq_busy_o;
  logic [63:0]         enq_instruction_i;
  logic [PC_BITS-1:0]  enq_pc_i;
  logic                enq_excp_vld_i;
  logic [3:0]          enq_excp_code_i;
  logic [IDX_BITS-1:0] enq_btb_idx_i;
  logic [1:0]          enq_btb_btype_i;
  logic [1:0]          enq_btb_bm_pred_i;
  logic [PC_BITS-1:0]  enq_btb_target_i;
  logic                enq_btb_vld_i;
  logic                enq_btb_way_i;

  logic                deq_valid_o;
  logic                deq_busy_i;
  logic [63:0]         deq_instruction_o;
  logic [PC_BITS-1:0]  deq_pc_o;
  logic                deq_excp_vld_o;
  logic [3:0]          deq_excp_code_o;
  logic [IDX_BITS-1:0] deq_btb_idx_o;
  logic [1:0]          deq_btb_btype_o;
  logic [1:0]          deq_btb_bm_pred_o;
  logic [PC_BITS-1:0]  deq_btb_target_o;
  logic                deq_btb_vld_o;
  logic                deq_btb_way_o;

  modport master (
    output enq_valid_i, enq_instruction_i, enq_pc_i,
    output enq_excp_vld_i, enq_excp_code_i,
    output enq_btb_idx_i, enq_btb_btype_i, enq_btb_bm_pred_i,
    output enq_btb_target_i, enq_btb_vld_i, enq_btb_way_i,
    output deq_busy_i,
    input  enq_busy_o, deq_valid_o,
    input  deq_instruction_o, deq_pc_o,
    input  deq_excp_vld_o, deq_excp_code_o,
    input  deq_btb_idx_o, deq_btb_btype_o, deq_btb_bm_pred_o,
    input  deq_btb_target_o, deq_btb_vld_o, deq_btb_way_o
  );

  modport slave (
    input  enq_valid_i, enq_instruction_i, enq_pc_i,
    input  enq_excp_vld_i, enq_excp_code_i,
    input  enq_btb_idx_i, enq_btb_btype_i, enq_btb_bm_pred_i,
    input  enq_btb_target_i, enq_btb_vld_i, enq_btb_way_i,
    input  deq_busy_i,
    output enq_busy_o, deq_valid_o,
    output deq_instruction_o, deq_pc_o,
    output deq_excp_vld_o, deq_excp_code_o,
    output deq_btb_idx_o, deq_btb_btype_o, deq_btb_bm_pred_o,
    output deq_btb_target_o, deq_btb_vld_o, deq_btb_way_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch-packet queue between instruction cache and decode.
// Sticky exception block stops intake after a faulting packet until flush.
module fetch_queue #(
  parameter int DEPTH              = 4,
  parameter bit ENABLE_C_EXTENSION = 1'b0,
  parameter int CNT_BITS           = $clog2(DEPTH) + 1
) (
  input  logic                core_clock_i,
  input  logic                core_reset_i,
  input  logic                core_flush_i,
  fetch_queue_if.slave        io,
  output logic [CNT_BITS-1:0] occupancy_o
);
  localparam int PC_BITS  = ENABLE_C_EXTENSION ? 31 : 30;
  localparam int IDX_BITS = ENABLE_C_EXTENSION ? 2 : 1;
  localparam int PTR_BITS = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]         instruction;
    logic [PC_BITS-1:0]  pc;
    logic                excp_vld;
    logic [3:0]          excp_code;
    logic [IDX_BITS-1:0] btb_idx;
    logic [1:0]          btb_btype;
    logic [1:0]          btb_bm_pred;
    logic [PC_BITS-1:0]  btb_target;
    logic                btb_vld;
    logic                btb_way;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              wr_entry;
  entry_t              rd_entry;
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                excp_q, excp_d;
  logic                full;
  logic                enq_busy;
  logic                deq_valid;
  logic                enq_fire;
  logic                deq_fire;

  // Busy comes from registers only, so a same-cycle dequeue never frees a slot.
  assign full      = (count_q == CNT_BITS'(DEPTH));
  assign enq_busy  = full | excp_q;
  assign deq_valid = (count_q != '0);
  assign enq_fire  = io.enq_valid_i & ~enq_busy;
  assign deq_fire  = deq_valid & ~io.deq_busy_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    excp_d  = excp_q;
    if (core_flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      excp_d  = 1'b0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + PTR_BITS'(1);
        excp_d = excp_q | io.enq_excp_vld_i;
      end
      if (deq_fire) begin
        head_d = head_q + PTR_BITS'(1);
      end
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      excp_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      excp_q  <= excp_d;
    end
  end

  always_comb begin
    wr_entry             = '0;
    wr_entry.instruction = io.enq_instruction_i;
    wr_entry.pc          = io.enq_pc_i;
    wr_entry.excp_vld    = io.enq_excp_vld_i;
    wr_entry.excp_code   = io.enq_excp_code_i;
    wr_entry.btb_idx     = io.enq_btb_idx_i;
    wr_entry.btb_btype   = io.enq_btb_btype_i;
    wr_entry.btb_bm_pred = io.enq_btb_bm_pred_i;
    wr_entry.btb_target  = io.enq_btb_target_i;
    wr_entry.btb_vld     = io.enq_btb_vld_i;
    wr_entry.btb_way     = io.enq_btb_way_i;
  end

  // Payload RAM carries no reset; validity lives in count_q.
  always_ff @(posedge core_clock_i) begin
    if (enq_fire && !core_flush_i) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign rd_entry             = mem_q[head_q];
  assign io.enq_busy_o        = enq_busy;
  assign io.deq_valid_o       = deq_valid;
  assign io.deq_instruction_o = rd_entry.instruction;
  assign io.deq_pc_o          = rd_entry.pc;
  assign io.deq_excp_vld_o    = rd_entry.excp_vld;
  assign io.deq_excp_code_o   = rd_entry.excp_code;
  assign io.deq_btb_idx_o     = rd_entry.btb_idx;
  assign io.deq_btb_btype_o   = rd_entry.btb_btype;
  assign io.deq_btb_bm_pred_o = rd_entry.btb_bm_pred;
  assign io.deq_btb_target_o  = rd_entry.btb_target;
  assign io.deq_btb_vld_o     = rd_entry.btb_vld;
  assign io.deq_btb_way_o     = rd_entry.btb_way;
  assign occupancy_o          = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at DEPTH=4, 30-bit PCs.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_fetch_queue;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] occ;
  int         checks;
  int         failures;

  fetch_queue_if #(.ENABLE_C_EXTENSION(1'b0)) bus ();

  fetch_queue #(
    .DEPTH(4),
    .ENABLE_C_EXTENSION(1'b0)
  ) dut (
    .core_clock_i(clk),
    .core_reset_i(rst),
    .core_flush_i(flush),
    .io(bus),
    .occupancy_o(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [29:0] pc, input logic excp);
    bus.enq_valid_i       = 1'b1;
    bus.enq_pc_i          = pc;
    bus.enq_instruction_i = {32'hA000_0000 | 32'(pc), 32'h5000_0000 | 32'(pc)};
    bus.enq_excp_vld_i    = excp;
    bus.enq_excp_code_i   = excp ? 4'h1 : 4'h0;
    bus.enq_btb_target_i  = pc + 30'h100;
    bus.enq_btb_idx_i     = pc[0];
    bus.enq_btb_btype_i   = pc[2:1];
    bus.enq_btb_bm_pred_i = pc[3:2];
    bus.enq_btb_vld_i     = pc[1];
    bus.enq_btb_way_i     = pc[0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    chk("reset_deq_valid", 64'(bus.deq_valid_o), 64'd0);
    chk("reset_enq_busy", 64'(bus.enq_busy_o), 64'd0);
    chk("reset_occupancy", 64'(occ), 64'd0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    bus.deq_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(30'h10 + 30'(i), 1'b0);
      step();
    end
    chk("fill_occupancy", 64'(occ), 64'd4);
    chk("fill_busy", 64'(bus.enq_busy_o), 64'd1);
    offer(30'h14, 1'b0);
    step();
    chk("fill_fifth_rejected", 64'(occ), 64'd4);
    bus.enq_valid_i = 1'b0;
    bus.deq_busy_i  = 1'b0;
    chk("fill_head_instr", bus.deq_instruction_o, 64'hA000_0010_5000_0010);
    chk("fill_head_target", 64'(bus.deq_btb_target_o), 64'h110);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(bus.deq_valid_o), 64'd1);
      chk("drain_pc", 64'(bus.deq_pc_o), 64'h10 + 64'(i));
      step();
    end
    chk("drain_empty", 64'(bus.deq_valid_o), 64'd0);
  endtask

  task automatic test_stream();
    bus.deq_busy_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      offer(30'h20 + 30'(i), 1'b0);
      step();
      chk("stream_pc", 64'(bus.deq_pc_o), 64'h20 + 64'(i));
      chk("stream_occ", 64'(occ), 64'd1);
    end
    bus.enq_valid_i = 1'b0;
    step();
    chk("stream_end_occ", 64'(occ), 64'd0);
  endtask

  task automatic test_full_simul();
    bus.deq_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(30'h30 + 30'(i), 1'b0);
      step();
    end
    offer(30'h34, 1'b0);
    bus.deq_busy_i = 1'b0;
    step();
    bus.enq_valid_i = 1'b0;
    chk("simul_occ", 64'(occ), 64'd3);
    chk("simul_busy", 64'(bus.enq_busy_o), 64'd0);
    for (int i = 1; i < 4; i++) begin
      chk("simul_drain_pc", 64'(bus.deq_pc_o), 64'h30 + 64'(i));
      step();
    end
    chk("simul_no_extra", 64'(bus.deq_valid_o), 64'd0);
  endtask

  task automatic test_excp_block();
    bus.deq_busy_i = 1'b1;
    offer(30'h40, 1'b1);
    step();
    chk("excp_busy", 64'(bus.enq_busy_o), 64'd1);
    chk("excp_occ", 64'(occ), 64'd1);
    chk("excp_code", 64'(bus.deq_excp_code_o), 64'h1);
    chk("excp_vld", 64'(bus.deq_excp_vld_o), 64'd1);
    offer(30'h41, 1'b0);
    step();
    step();
    chk("excp_dropped", 64'(occ), 64'd1);
    bus.enq_valid_i = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("excp_flush_occ", 64'(occ), 64'd0);
    chk("excp_flush_busy", 64'(bus.enq_busy_o), 64'd0);
  endtask

  task automatic test_flush_vs_enq();
    bus.deq_busy_i = 1'b1;
    offer(30'h50, 1'b0);
    step();
    offer(30'h51, 1'b0);
    step();
    chk("fve_pre_occ", 64'(occ), 64'd2);
    offer(30'h52, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.enq_valid_i = 1'b0;
    chk("fve_occ", 64'(occ), 64'd0);
    chk("fve_valid", 64'(bus.deq_valid_o), 64'd0);
    offer(30'h60, 1'b0);
    step();
    bus.enq_valid_i = 1'b0;
    chk("fve_next_pc", 64'(bus.deq_pc_o), 64'h60);
    chk("fve_next_occ", 64'(occ), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.deq_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(30'h70 + 30'(i), 1'b0);
      step();
    end
    bus.enq_valid_i = 1'b0;
    chk("ar_pre_occ", 64'(occ), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.deq_valid_o), 64'd0);
    chk("ar_occ", 64'(occ), 64'd0);
    #1;
    rst = 1'b0;
    offer(30'h7A, 1'b0);
    step();
    bus.enq_valid_i = 1'b0;
    chk("ar_first_enq_occ", 64'(occ), 64'd1);
    chk("ar_first_enq_pc", 64'(bus.deq_pc_o), 64'h7A);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    bus.deq_busy_i = 1'b0;
    offer(30'h0, 1'b0);
    bus.enq_valid_i = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_simul();
    test_excp_block();
    test_flush_vs_enq();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of fetch-packet entries; SHALL be a power of two and at least 2.
REQ-002 Parameter ENABLE_C_EXTENSION, default 0: SHALL set PC_BITS = 31 when 1, else 30, and IDX_BITS = 2 when 1, else 1.
REQ-003 Parameter CNT_BITS = $clog2(DEPTH)+1: occupancy width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 core_clock_i  in  1  the single clock.
REQ-006 core_reset_i  in  1  asynchronous, active-high reset.
REQ-007 core_flush_i  in  1  synchronous queue flush, driven as core flush OR branch correct.
REQ-008 enq_valid_i  in  1  packet offered by the instruction cache.
REQ-009 enq_busy_o  out  1  back-pressure to the instruction cache.
REQ-010 enq_instruction_i  in  64  two 32-bit instruction slots.
REQ-011 enq_pc_i  in  PC_BITS  packet PC.
REQ-012 enq_excp_vld_i / enq_excp_code_i  in  1 / 4  fetch exception and its code.
REQ-013 enq_btb_idx_i  in  IDX_BITS; enq_btb_btype_i  in  2; enq_btb_bm_pred_i  in  2; enq_btb_target_i  in  PC_BITS; enq_btb_vld_i  in  1; enq_btb_way_i  in  1: BTB prediction metadata.
REQ-014 deq_valid_o  out  1  head entry present.
REQ-015 deq_* outputs SHALL mirror every enq_* payload field listed in REQ-010 to REQ-013, at the same widths.
REQ-016 deq_busy_i  in  1  decode is stalled.
REQ-017 occupancy_o  out  CNT_BITS  current entry count.

Function
REQ-018 Enqueue SHALL occur when enq_valid_i && !enq_busy_o; write at tail, tail advances by 1 modulo DEPTH.
REQ-019 Dequeue SHALL occur when deq_valid_o && !deq_busy_i; head advances by 1 modulo DEPTH.
REQ-020 deq_valid_o SHALL equal (count != 0); deq_* SHALL be driven from the head storage entry. There is no combinational enq-to-deq bypass: latency is 1 cycle from an accepted enqueue on an empty queue.
REQ-021 count SHALL update as +1 on enqueue only, -1 on dequeue only, and stay unchanged on both together; occupancy_o = count.
REQ-022 enq_busy_o SHALL equal (count == DEPTH) OR excp_block, computed from registers only, with no dependence on deq_busy_i.
REQ-023 When full, a same-cycle dequeue SHALL NOT free space for an enqueue in that cycle.
REQ-024 excp_block (sticky) SHALL set on the edge that accepts a packet with enq_excp_vld_i = 1; no later packet is accepted until flush.
REQ-025 excp_block SHALL be cleared only by core_flush_i or reset.
REQ-026 Flush has priority over every same-cycle enqueue and dequeue. Head, tail and count SHALL go to 0 and excp_block to 0 at the next edge; entry payload need not be cleared.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-028 Payload storage SHALL be written only on an accepted enqueue.

Reset
REQ-029 On core_reset_i = 1, asynchronously: head = tail = count = 0 and excp_block = 0, so deq_valid_o = 0, enq_busy_o = 0 and occupancy_o = 0. deq_* payload is don't-care while deq_valid_o = 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately; the first enqueue after deassertion SHALL be accepted on the first edge.

Verification
REQ-031 Fill/drain, DEPTH = 4, deq_busy_i = 1: enqueue PCs 0x10, 0x11, 0x12, 0x13 -> occupancy_o = 4 and enq_busy_o = 1; 5th offer 0x14 is not accepted. Release deq_busy_i -> deq_pc_o is 0x10, 0x11, 0x12, 0x13 on consecutive cycles, then deq_valid_o = 0.
REQ-032 Wrap and stream: continuous enqueue and dequeue with deq_busy_i = 0 for 10 packets, PCs 0x20 to 0x29 -> output order is exactly 0x20 to 0x29, occupancy_o stays at 1, and pointers wrap twice.
REQ-033 Full plus simultaneous events: count = 4, dequeue and enqueue offered in the same cycle -> the offered packet is rejected, count = 3 and enq_busy_o = 0 the next cycle.
REQ-034 Exception block: enqueue a packet with enq_excp_vld_i = 1 and code 4'h1 at count 0 -> enq_busy_o = 1 the next cycle with occupancy_o = 1, and further offers are dropped. Assert core_flush_i -> occupancy_o = 0 and enq_busy_o = 0.
REQ-035 Flush versus enqueue: count = 2 while core_flush_i = 1 and enq_valid_i = 1 in the same cycle -> the next cycle shows occupancy_o = 0 and deq_valid_o = 0, and the offered packet is not stored.
REQ-036 Asynchronous reset: with count = 3, pulse core_reset_i between clock edges -> deq_valid_o = 0 and occupancy_o = 0 before the next edge.
